// File: rtl/imem_loader_pkg.sv
// Shared state encoding and stream-format constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    WORD,
    CHK,
    FIN,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader_wordpack.sv
// Big-endian byte-to-word packer; word_vld is combinational on the 4th accepted byte.
// No backpressure of its own: the caller qualifies byte_vld with its ready.
module imem_loader_wordpack
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  logic [1:0]  byte_cnt;
  logic [23:0] shift_q;

  // Only the first three bytes need storage; the fourth is taken straight from the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      shift_q  <= '0;
    end else if (clr) begin
      byte_cnt <= '0;
    end else if (byte_vld) begin
      byte_cnt <= byte_cnt + 2'd1;
      shift_q  <= {shift_q[15:0], byte_dat};
    end
  end

  assign word_vld = byte_vld && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign word_dat = {shift_q, byte_dat};

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed big-endian program into instruction memory, holding the core in reset meanwhile.
// Write pulse lags the 4th byte by one cycle; IMEM_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 32,
  parameter int BOOT_HOLD = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic              IM_WE,
  output logic [ADDR_W-1:0] IM_ADDR,
  output logic [WIDTH-1:0]  IM_WDATA,
  output logic              CPU_RST,
  output logic              DONE,
  output logic              ERROR
);

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_full;
  logic [LEN_W-1:0] word_idx;
  logic             xfer;
  logic             word_vld;
  logic [31:0]      word_dat;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign xfer     = RX_VALID && RX_READY;
  assign len_full = {len[15:8], RX_DATA};

  imem_loader_wordpack u_wordpack (
    .clk      (CLK),
    .rst      (RST),
    .clr      (state != WORD),
    .byte_vld (xfer && (state == WORD)),
    .byte_dat (RX_DATA),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      RX_READY <= 1'b0;
      IM_WE    <= 1'b0;
      IM_ADDR  <= '0;
      IM_WDATA <= '0;
      CPU_RST  <= (BOOT_HOLD != 0);
      DONE     <= 1'b0;
      ERROR    <= 1'b0;
      len      <= '0;
      word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      IM_WE <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == IDLE && START)
        csum <= '0;
      else if (xfer)
        csum <= csum ^ RX_DATA;
`endif
      case (state)
        IDLE: begin
          if (START) begin
            state    <= LEN_HI;
            RX_READY <= 1'b1;
            CPU_RST  <= 1'b1;
            DONE     <= 1'b0;
            ERROR    <= 1'b0;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len[15:8] <= RX_DATA;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len <= len_full;
            if (len_full == '0) begin
              state    <= FIN;
              RX_READY <= 1'b0;
            end else if (len_full > LEN_W'(DEPTH)) begin
              state    <= ERR;
              RX_READY <= 1'b0;
            end else begin
              state    <= WORD;
              word_idx <= '0;
            end
          end
        end
        WORD: begin
          if (word_vld) begin
            IM_WE    <= 1'b1;
            IM_WDATA <= WIDTH'(word_dat);
            IM_ADDR  <= ADDR_W'({word_idx, 2'b00});
            word_idx <= word_idx + 1'b1;
            if (word_idx == len - 1'b1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= CHK;
`else
              state    <= FIN;
              RX_READY <= 1'b0;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          // csum still holds the XOR of every earlier byte on this edge.
          if (xfer) begin
            RX_READY <= 1'b0;
            state    <= (RX_DATA == csum) ? FIN : ERR;
          end
        end
`endif
        FIN: begin
          DONE    <= 1'b1;
          CPU_RST <= 1'b0;
          state   <= IDLE;
        end
        ERR: begin
          ERROR   <= 1'b1;
          CPU_RST <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state    <= IDLE;
          RX_READY <= 1'b0;
        end
      endcase
    end
  end

endmodule
